// File: rtl/param_wormhole_router.sv
// Five-port XY wormhole router: per-input FIFOs, per-output packet locks
// with round-robin arbitration among header flits routed to that output.
module param_wormhole_router #(
  parameter int FLIT_W       = 4,
  parameter int PKT_FLITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int COORD_W      = 2,
  parameter int X_COORDINATE = 1,
  parameter int Y_COORDINATE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5*FLIT_W-1:0] in_flit,
  input  logic [4:0]          in_valid,
  output logic [4:0]          in_ready,
  output logic [5*FLIT_W-1:0] out_flit,
  output logic [4:0]          out_valid,
  input  logic [4:0]          out_ready,
  output logic [4:0]          stall
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_COORDINATE);
  localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_COORDINATE);
  localparam logic [CW-1:0] LAST_CNT = CW'(PKT_FLITS - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {LK_IDLE, LK_LOCKED} lock_t;

  function automatic logic [2:0] route(input logic [FLIT_W-1:0] f);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = f[COORD_W-1:0];
    dy = f[2*COORD_W-1:COORD_W];
    if (dx > MY_X)      route = 3'd3;
    else if (dx < MY_X) route = 3'd4;
    else if (dy > MY_Y) route = 3'd1;
    else if (dy < MY_Y) route = 3'd2;
    else                route = 3'd0;
  endfunction

  function automatic logic [2:0] wrap5(input logic [3:0] v);
    wrap5 = (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  logic [FLIT_W-1:0] head [5];
  logic [2:0]        route_dir [5];
  logic [2:0]        owner_arr [5];
  logic [4:0]        fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [4:0]        locked, owned, xfer;

  genvar gi;
  for (gi = 0; gi < 5; gi++) begin : g_in
    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]       count_reg;

    assign fifo_empty[gi] = (count_reg == '0);
    assign fifo_full[gi]  = (count_reg == FULL_CNT);
    // Full refuses writes regardless of a concurrent pop.
    assign in_ready[gi]   = reset & ~fifo_full[gi];
    assign fifo_push[gi]  = in_valid[gi] & in_ready[gi];
    assign head[gi]       = mem[rd_ptr_reg];
    assign route_dir[gi]  = route(head[gi]);
    assign stall[gi]      = ~fifo_empty[gi] & ~fifo_pop[gi];

    always_ff @(posedge clk) begin
      if (fifo_push[gi]) mem[wr_ptr_reg] <= in_flit[gi*FLIT_W +: FLIT_W];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        count_reg <= count_reg + (AW + 1)'(fifo_push[gi]) - (AW + 1)'(fifo_pop[gi]);
      end
    end
  end

  // An input whose packet is in flight is never a header candidate elsewhere.
  always_comb begin
    owned    = '0;
    fifo_pop = '0;
    for (int o = 0; o < 5; o++) begin
      if (locked[o]) begin
        owned[owner_arr[o]]    = 1'b1;
        fifo_pop[owner_arr[o]] = fifo_pop[owner_arr[o]] | xfer[o];
      end
    end
  end

  for (gi = 0; gi < 5; gi++) begin : g_out
    lock_t             state_reg, state_next;
    logic [2:0]        owner_reg, owner_next;
    logic [2:0]        ptr_reg, ptr_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [4:0]        req;
    logic [2:0]        winner, idx;
    logic              found;
    logic              out_valid_w;
    logic [FLIT_W-1:0] out_flit_w;

    always_comb begin
      req    = '0;
      winner = ptr_reg;
      found  = 1'b0;
      idx    = '0;
      for (int p = 0; p < 5; p++) begin
        req[p] = ~fifo_empty[p] & ~owned[p] & (route_dir[p] == 3'(gi));
      end
      for (int i = 0; i < 5; i++) begin
        idx = wrap5({1'b0, ptr_reg} + 4'(i));
        if (!found && req[idx]) begin
          winner = idx;
          found  = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_reg <= LK_IDLE;
        owner_reg <= '0;
        ptr_reg   <= '0;
        cnt_reg   <= '0;
      end else begin
        state_reg <= state_next;
        owner_reg <= owner_next;
        ptr_reg   <= ptr_next;
        cnt_reg   <= cnt_next;
      end
    end

    always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      ptr_next   = ptr_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
        LK_IDLE: begin
          if (found) begin
            state_next = LK_LOCKED;
            owner_next = winner;
            cnt_next   = '0;
            ptr_next   = wrap5({1'b0, winner} + 4'd1);
          end
        end
        LK_LOCKED: begin
          if (xfer[gi]) begin
            if (cnt_reg == LAST_CNT) begin
              state_next = LK_IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
        end
        default: state_next = LK_IDLE;
      endcase
    end

    always_comb begin
      out_valid_w = 1'b0;
      out_flit_w  = '0;
      if (state_reg == LK_LOCKED) begin
        out_valid_w = ~fifo_empty[owner_reg];
        out_flit_w  = head[owner_reg];
      end
    end

    assign locked[gi]                       = (state_reg == LK_LOCKED);
    assign owner_arr[gi]                    = owner_reg;
    assign out_valid[gi]                    = out_valid_w;
    assign out_flit[gi*FLIT_W +: FLIT_W]    = out_flit_w;
    assign xfer[gi]                         = out_valid_w & out_ready[gi];
  end
endmodule
